// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO: sign handling around unsigned cores, fixed-latency run, commit.
// Optional MADD/MADDU accumulate enabled by defining MULDIV_MADD_EN.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        hilo_rd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;

    logic [CW-1:0] cnt;
    logic [31:0]   a_q, b_q, src_q;
    logic          div_q, negp_q, negr_q, dz_q;
    logic          is_mul, is_div, rs_neg, rt_neg, accept, commit;
    logic [31:0]   abs_rs, abs_rt, quot, rem, quot_s, rem_s;
    logic [63:0]   product, mul_res, div_res, commit_val;

    assign is_div = (op[2:1] == 2'b01);
`ifdef MULDIV_MADD_EN
    logic madd_q;
    assign is_mul = (op[2:1] == 2'b00) | (op[2:1] == 2'b11);
`else
    assign is_mul = (op[2:1] == 2'b00);
`endif
    // Even op codes are the signed variants.
    assign rs_neg = ~op[0] & rs[31];
    assign rt_neg = ~op[0] & rt[31];
    assign abs_rs = rs_neg ? (32'd0 - rs) : rs;
    assign abs_rt = rt_neg ? (32'd0 - rt) : rt;

    assign busy  = (state == RUN);
    assign stall = busy & (start | hilo_rd);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: if (start && (is_mul || is_div)) begin
                accept  = 1'b1;
                state_n = RUN;
            end
            RUN: if (cnt == '0) begin
                commit  = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Unsigned cores fed only from the latched operands.
    assign product = {32'd0, a_q} * {32'd0, b_q};
    assign quot    = (b_q == '0) ? '0 : a_q / b_q;
    assign rem     = (b_q == '0) ? '0 : a_q % b_q;
    assign mul_res = negp_q ? (64'd0 - product) : product;
    assign quot_s  = negp_q ? (32'd0 - quot) : quot;
    assign rem_s   = negr_q ? (32'd0 - rem) : rem;
    assign div_res = dz_q ? {src_q, {32{1'b1}}} : {rem_s, quot_s};

    always_comb begin
        commit_val = div_q ? div_res : mul_res;
`ifdef MULDIV_MADD_EN
        if (madd_q) commit_val = {hi, lo} + mul_res;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            src_q  <= '0;
            div_q  <= 1'b0;
            negp_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
`ifdef MULDIV_MADD_EN
            madd_q <= 1'b0;
`endif
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= commit;
            if (accept) begin
                a_q    <= abs_rs;
                b_q    <= abs_rt;
                src_q  <= rs;
                div_q  <= is_div;
                negp_q <= rs_neg ^ rt_neg;
                negr_q <= rs_neg;
                dz_q   <= (rt == '0);
`ifdef MULDIV_MADD_EN
                madd_q <= (op[2:1] == 2'b11);
`endif
                cnt    <= is_div ? DIV_LAST : MUL_LAST;
            end else if (busy && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                {hi, lo} <= commit_val;
            end else if (state == IDLE && start && op == 3'b100) begin
                hi <= rs;
            end else if (state == IDLE && start && op == 3'b101) begin
                lo <= rs;
            end
        end
    end

endmodule
